regfile_phase_sequencer: RTL and testbench

//   Sequences the 5-phase instruction cycle around the 8x16 register file.

---
 rtl/regfile_phase_sequencer.sv | 147 ++++++++++++++
 tb/tb_regfile_phase_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_phase_sequencer.sv
// Five-phase instruction sequencer for the 8x16 register file, with run/step/halt
// control and a halted-only valid/ready dump of r0..r7 through the Rs read port.
module regfile_phase_sequencer #(
  parameter int NUM_PHASES = 5,
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  step,
  input  logic                  haltReq,
  input  logic                  stall,
  output logic [NUM_PHASES-1:0] phase,
  output logic                  changeEnable,
  output logic                  running,
  output logic                  halted,
  input  logic                  dumpReq,
  output logic                  dumpActive,
  output logic [ADDR_W-1:0]     dumpAddr,
  input  logic [DATA_W-1:0]     regData,
  output logic [DATA_W-1:0]     dumpData,
  output logic                  dumpValid,
  input  logic                  dumpReady
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_DUMP_LOAD = 2'd2,
    S_DUMP_SEND = 2'd3
  } state_e;

  localparam logic [NUM_PHASES-1:0] PHASE_FIRST = {{(NUM_PHASES-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]     ADDR_LAST   = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0]     ADDR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e                state_q,     state_d;
  logic [NUM_PHASES-1:0] phase_q,     phase_d;
  logic                  step_mode_q, step_mode_d;
  logic [ADDR_W-1:0]     dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0]     dump_data_q, dump_data_d;
  logic                  dump_valid_q, dump_valid_d;
  logic                  boundary_s;

  // The write strobe marks the instruction boundary: last phase, not stalled.
  assign boundary_s = (state_q == S_RUN) && phase_q[NUM_PHASES-1] && !stall;

  // Next-state and datapath-register update for the sequencer FSM.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    step_mode_d  = step_mode_q;
    dump_addr_d  = dump_addr_q;
    dump_data_d  = dump_data_q;
    dump_valid_d = dump_valid_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d     = S_RUN;
          phase_d     = PHASE_FIRST;
          step_mode_d = 1'b0;
        end else if (step) begin
          state_d     = S_RUN;
          phase_d     = PHASE_FIRST;
          step_mode_d = 1'b1;
        end else if (dumpReq) begin
          state_d     = S_DUMP_LOAD;
          dump_addr_d = {ADDR_W{1'b0}};
        end else begin
          state_d     = S_IDLE;
        end
      end
      S_RUN: begin
        if (stall) begin
          phase_d = phase_q;
        end else if (phase_q[NUM_PHASES-1]) begin
          // run only gates new instructions; an instruction in flight always finishes.
          if (haltReq || step_mode_q || !run) begin
            state_d     = S_IDLE;
            phase_d     = {NUM_PHASES{1'b0}};
            step_mode_d = 1'b0;
          end else begin
            phase_d     = PHASE_FIRST;
          end
        end else begin
          phase_d = {phase_q[NUM_PHASES-2:0], 1'b0};
        end
      end
      S_DUMP_LOAD: begin
        dump_data_d  = regData;
        dump_valid_d = 1'b1;
        state_d      = S_DUMP_SEND;
      end
      S_DUMP_SEND: begin
        if (dump_valid_q && dumpReady) begin
          dump_valid_d = 1'b0;
          if (dump_addr_q == ADDR_LAST) begin
            state_d     = S_IDLE;
            dump_addr_d = {ADDR_W{1'b0}};
          end else begin
            state_d     = S_DUMP_LOAD;
            dump_addr_d = dump_addr_q + ADDR_ONE;
          end
        end else begin
          state_d = S_DUMP_SEND;
        end
      end
      default: begin
        state_d      = S_IDLE;
        phase_d      = {NUM_PHASES{1'b0}};
        step_mode_d  = 1'b0;
        dump_addr_d  = {ADDR_W{1'b0}};
        dump_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any instruction or dump in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      phase_q      <= {NUM_PHASES{1'b0}};
      step_mode_q  <= 1'b0;
      dump_addr_q  <= {ADDR_W{1'b0}};
      dump_data_q  <= {DATA_W{1'b0}};
      dump_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      step_mode_q  <= step_mode_d;
      dump_addr_q  <= dump_addr_d;
      dump_data_q  <= dump_data_d;
      dump_valid_q <= dump_valid_d;
    end
  end

  assign phase        = phase_q;
  assign changeEnable = boundary_s;
  assign running      = (state_q == S_RUN);
  assign halted       = (state_q == S_IDLE);
  assign dumpActive   = (state_q == S_DUMP_LOAD) || (state_q == S_DUMP_SEND);
  assign dumpAddr     = dump_addr_q;
  assign dumpData     = dump_data_q;
  assign dumpValid    = dump_valid_q;

endmodule

// File: tb/tb_regfile_phase_sequencer.sv
// Bench for regfile_phase_sequencer: directed scenarios plus random stimulus,
// all checked against a cycle-level behavioural model of the sequencer.
module tb_regfile_phase_sequencer;

  logic        clock = 1'b0;
  logic        reset, run, step, haltReq, stall, dumpReq, dumpReady;
  logic [4:0]  phase;
  logic        changeEnable, running, halted, dumpActive, dumpValid;
  logic [2:0]  dumpAddr;
  logic [15:0] regData, dumpData;

  logic [15:0] rf [8];
  assign regData = rf[dumpAddr];

  regfile_phase_sequencer dut (
    .clock(clock), .reset(reset), .run(run), .step(step), .haltReq(haltReq),
    .stall(stall), .phase(phase), .changeEnable(changeEnable), .running(running),
    .halted(halted), .dumpReq(dumpReq), .dumpActive(dumpActive), .dumpAddr(dumpAddr),
    .regData(regData), .dumpData(dumpData), .dumpValid(dumpValid), .dumpReady(dumpReady)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0=idle 1=run 2=dump-load 3=dump-send, phase as an index.
  int          m_mode, m_pidx, m_addr;
  bit          m_step, m_valid;
  logic [15:0] m_data;

  int          ce_cnt, run_cyc;
  logic [15:0] got_q [$];
  logic [2:0]  got_a [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_mode = 0; m_pidx = 0; m_step = 1'b0; m_addr = 0; m_data = 16'h0000; m_valid = 1'b0;
    end else begin
      case (m_mode)
        0: begin
          if (run)          begin m_mode = 1; m_pidx = 0; m_step = 1'b0; end
          else if (step)    begin m_mode = 1; m_pidx = 0; m_step = 1'b1; end
          else if (dumpReq) begin m_mode = 2; m_addr = 0; end
        end
        1: begin
          if (!stall) begin
            if (m_pidx == 4) begin
              if (haltReq || m_step || !run) m_mode = 0;
              else m_pidx = 0;
            end else begin
              m_pidx++;
            end
          end
        end
        2: begin m_data = rf[m_addr]; m_valid = 1'b1; m_mode = 3; end
        3: begin
          if (dumpReady) begin
            m_valid = 1'b0;
            if (m_addr == 7) begin m_mode = 0; m_addr = 0; end
            else begin m_addr++; m_mode = 2; end
          end
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  // Called at a falling edge with inputs already driven: compare, clock, advance model.
  task automatic tick();
    logic [4:0] exp_phase;
    #1;
    exp_phase = (m_mode == 1) ? 5'(32'd1 << m_pidx) : 5'd0;
    chk("phase",        32'(phase),        32'(exp_phase));
    chk("changeEnable", 32'(changeEnable), 32'(m_mode == 1 && m_pidx == 4 && !stall));
    chk("running",      32'(running),      32'(m_mode == 1));
    chk("halted",       32'(halted),       32'(m_mode == 0));
    chk("dumpActive",   32'(dumpActive),   32'(m_mode >= 2));
    chk("dumpAddr",     32'(dumpAddr),     32'(m_addr));
    chk("dumpData",     32'(dumpData),     32'(m_data));
    chk("dumpValid",    32'(dumpValid),    32'(m_valid));
    if (changeEnable) ce_cnt++;
    if (running) run_cyc++;
    if (dumpValid && dumpReady) begin
      got_q.push_back(dumpData);
      got_a.push_back(dumpAddr);
    end
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic drain_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (m_mode == 0) break;
      tick();
    end
  endtask

  initial begin
    int n, hold, held_n;
    reset = 1'b1; run = 1'b0; step = 1'b0; haltReq = 1'b0; stall = 1'b0;
    dumpReq = 1'b0; dumpReady = 1'b1;
    for (int i = 0; i < 8; i++) rf[i] = 16'(16'h1111 * i);
    @(negedge clock); @(negedge clock);
    model_step();
    tick();
    reset = 1'b0;
    chk("rst_phase",  32'(phase),      32'd0);
    chk("rst_halted", 32'(halted),     32'd1);
    chk("rst_valid",  32'(dumpValid),  32'd0);
    chk("rst_addr",   32'(dumpAddr),   32'd0);
    chk("rst_active", 32'(dumpActive), 32'd0);

    // Single step: phases P1..P5, one strobe, back to idle.
    ce_cnt = 0;
    step = 1'b1; tick(); step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("step_phase", 32'(phase), 32'd1 << i);
      tick();
    end
    chk("step_ce",     32'(ce_cnt), 32'd1);
    chk("step_halted", 32'(halted), 32'd1);

    // Free run halted by haltReq at the third instruction's P5.
    ce_cnt = 0; run_cyc = 0;
    run = 1'b1; tick();
    for (int k = 0; k < 40; k++) begin
      haltReq = (m_mode == 1 && m_pidx == 4 && ce_cnt == 2);
      tick();
      if (ce_cnt >= 3) break;
    end
    run = 1'b0; haltReq = 1'b0;
    chk("halt_ce",     32'(ce_cnt),  32'd3);
    chk("halt_cycles", 32'(run_cyc), 32'd15);
    chk("halt_idle",   32'(halted),  32'd1);
    tick();

    // Stall held for 4 cycles in P5.
    run = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (m_mode == 1 && m_pidx == 4) break;
      tick();
    end
    ce_cnt = 0; stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("stall_phase", 32'(phase), 32'h10);
      tick();
    end
    chk("stall_ce0", 32'(ce_cnt), 32'd0);
    stall = 1'b0; run = 1'b0;
    tick();
    chk("stall_ce1",   32'(ce_cnt), 32'd1);
    chk("stall_idle",  32'(halted), 32'd1);

    // run dropped during P2: instruction still completes.
    run = 1'b1; tick(); tick();
    chk("drop_p2", 32'(phase), 32'h02);
    run = 1'b0; ce_cnt = 0; n = 0;
    for (int k = 0; k < 8; k++) begin
      if (m_mode == 0) break;
      tick(); n++;
    end
    chk("drop_ce",  32'(ce_cnt), 32'd1);
    chk("drop_len", 32'(n),      32'd4);

    // step and run together: free-running, not single-step.
    step = 1'b1; run = 1'b1; tick(); step = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("steprun_free", 32'(running), 32'd1);
    run = 1'b0; drain_idle(8);

    // Full dump of r0..r7 with dumpReady held high.
    got_q.delete(); got_a.delete();
    dumpReady = 1'b1; dumpReq = 1'b1; tick(); dumpReq = 1'b0;
    drain_idle(40);
    chk("dump_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      chk("dump_word", 32'(got_q[i]), 32'(16'h1111 * i));
      chk("dump_addr", 32'(got_a[i]), 32'(i));
    end
    chk("dump_idle", 32'(halted), 32'd1);

    // Backpressure of 3 cycles on word 2.
    got_q.delete(); got_a.delete();
    hold = 3; held_n = 0;
    dumpReq = 1'b1; tick(); dumpReq = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (m_mode == 0) break;
      dumpReady = !(m_mode == 3 && m_addr == 2 && hold > 0);
      if (!dumpReady) begin
        hold--; held_n++;
        chk("hold_data",  32'(dumpData),  32'h2222);
        chk("hold_valid", 32'(dumpValid), 32'd1);
      end
      tick();
    end
    dumpReady = 1'b1;
    chk("hold_n",     32'(held_n),       32'd3);
    chk("hold_count", 32'(got_q.size()), 32'd8);
    if (got_q.size() > 2) chk("hold_word2", 32'(got_q[2]), 32'h2222);

    // Reset in DUMP_SEND at dumpAddr 5.
    dumpReq = 1'b1; tick(); dumpReq = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (m_mode == 3 && m_addr == 5) break;
      tick();
    end
    chk("pre_rst_addr", 32'(dumpAddr), 32'd5);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("abort_valid",  32'(dumpValid),  32'd0);
    chk("abort_active", 32'(dumpActive), 32'd0);
    chk("abort_addr",   32'(dumpAddr),   32'd0);
    chk("abort_halted", 32'(halted),     32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
    for (int k = 0; k < 3000; k++) begin
      run       = ($urandom_range(0, 3) == 0);
      step      = ($urandom_range(0, 5) == 0);
      haltReq   = ($urandom_range(0, 3) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      dumpReq   = ($urandom_range(0, 4) == 0);
      dumpReady = ($urandom_range(0, 1) == 0);
      reset     = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
